// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Holds the program counter and fetches one instruction word at a time over
// a req/ack instruction-memory port. The word is presented to decode as
// instr/opcode/funct until the datapath retires it. The next PC is then
// chosen from the controller's npc_sel/j_ctl/jr_ctl, the ALU zero flag and
// the rs value used by jr.
//
// Ports
//   clk          : single clock; all state updates on posedge
//   rst_n        : asynchronous, active-low reset
//   imem_req     : fetch request, held high until imem_ack (combinational)
//   imem_addr    : word-aligned fetch address (equals pc)
//   imem_ack     : read data valid this cycle
//   imem_rdata   : instruction word, sampled when imem_ack is high
//   instr        : current instruction word
//   opcode       : instr[31:26]
//   funct        : instr[5:0]
//   instr_valid  : instr is valid for decode/execute
//   instr_done   : datapath retires the current instruction this cycle
//   npc_sel      : non-sequential next PC
//   j_ctl        : j/jal
//   jr_ctl       : jr
//   zero         : ALU result is zero (beq taken)
//   jr_target    : GPR[rs] for jr
//   pc           : PC of the current instruction
//   pc_plus4     : pc + 4 (jal link value)
//   addr_err     : one-cycle pulse after a retired jr with misaligned target
//   retired_cnt  : number of retired instructions, wraps at 2^CNT_W
//
// State table
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_FETCH | request pending at pc; waiting (indefinitely) for imem_ack
//   S_EXEC  | instr valid; waiting for instr_done to retire and pick next pc
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,

    output logic [31:0]      instr,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic             instr_valid,

    input  logic             instr_done,
    input  logic             npc_sel,
    input  logic             j_ctl,
    input  logic             jr_ctl,
    input  logic             zero,
    input  logic [31:0]      jr_target,

    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             addr_err,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    state_t             state;
    logic [31:0]        pc_q;
    logic [31:0]        instr_q;
    logic               instr_valid_q;
    logic               addr_err_q;
    logic [CNT_W-1:0]   retired_cnt_q;

    logic [31:0]        seq_pc;
    logic [31:0]        br_offset;
    logic [31:0]        br_target;
    logic [31:0]        j_target;
    logic [31:0]        jr_aligned;
    logic [31:0]        next_pc;
    logic               jr_misaligned;
    logic               retire;

    // -----------------------------------------------------------------------
    // Candidate next-PC values. All adds wrap modulo 2^32.
    // -----------------------------------------------------------------------
    assign seq_pc     = pc_q + 32'd4;
    // Sign-extended word offset: 14 copies of the sign bit, imm16, then <<2.
    assign br_offset  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign br_target  = seq_pc + br_offset;
    // Jump region comes from the delay-slot-free pc+4, not pc.
    assign j_target   = {seq_pc[31:28], instr_q[25:0], 2'b00};
    // jr always fetches from a word boundary; low bits are only reported.
    assign jr_aligned = {jr_target[31:2], 2'b00};

    always_comb begin
        next_pc = seq_pc;
        if (!npc_sel) begin
            next_pc = seq_pc;
        end else if (jr_ctl) begin
            next_pc = jr_aligned;
        end else if (j_ctl) begin
            next_pc = j_target;
        end else if (zero) begin
            next_pc = br_target;
        end else begin
            next_pc = seq_pc;
        end
    end

    // A misaligned jr only counts when jr actually wins the priority chain.
    assign jr_misaligned = npc_sel & jr_ctl & (|jr_target[1:0]);

    // instr_done outside EXEC is ignored.
    assign retire = (state == S_EXEC) && instr_done;

    // -----------------------------------------------------------------------
    // Fetch/execute sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            addr_err_q <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        state         <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Late acks in EXEC are deliberately dropped.
                    if (retire) begin
                        pc_q          <= next_pc;
                        instr_valid_q <= 1'b0;
                        retired_cnt_q <= retired_cnt_q + CNT_W'(1);
                        addr_err_q    <= jr_misaligned;
                        state         <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = seq_pc;
    assign addr_err    = addr_err_q;
    assign retired_cnt = retired_cnt_q;

endmodule
